bit_serial_alu: RTL and testbench

- Multi-cycle, bit-serial WIDTH-bit ALU built around one instance of the team's 1-bit ALU slice cell.
- Each RUN cycle it feeds the slice one operand bit pair, LSB first, with a registered carry. It also collects the slice's result bit.
- Produces a full-width result with zero and overflow flags.
- Sits in the area-reduced datapath in place of a WIDTH-slice ripple ALU. It uses the same 4-bit ALU control encoding.

---
 rtl/alu_pkg.sv | 18 +
 rtl/ALU_1bit.sv | 26 ++
 rtl/bit_serial_alu.sv | 131 +++++++++++++
 tb/tb_bit_serial_alu.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control encodings and bit-serial ALU state encoding.
package alu_pkg;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_FINISH = 2'b10;
endpackage

// File: rtl/ALU_1bit.sv
// ALU_1bit: one-bit ALU slice with operand inversion, full adder and less pass-through.
import alu_pkg::*;

module ALU_1bit (
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       carry_in,
    input  logic       less,
    input  logic [1:0] operation,
    output logic       result,
    output logic       carry_out
);
    logic aa, bb, sum;

    always_comb begin
        aa        = a ^ a_invert;
        bb        = b ^ b_invert;
        sum       = aa ^ bb ^ carry_in;
        carry_out = (aa & bb) | (aa & carry_in) | (bb & carry_in);
        result    = (operation == OP_AND) ? (aa & bb) :
                    (operation == OP_OR)  ? (aa | bb) :
                    (operation == OP_ADD) ? sum : less;
    end
endmodule

// File: rtl/bit_serial_alu.sv
// bit_serial_alu: WIDTH-bit ALU evaluated LSB first through a single ALU_1bit slice.
import alu_pkg::*;

module bit_serial_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       ctrl_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             zero_out,
    output logic             overflow_out
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, r_sh_q, r_sh_d;
    logic [WIDTH-1:0] result_q, result_d, fin;
    logic             carry_q, carry_d, ovf_q, ovf_d, set_q, set_d;
    logic             zero_q, zero_d, ovf_out_q, ovf_out_d, done_q, done_d;
    logic [1:0]       slice_op;
    logic             slice_res, slice_co;

    // SLT is a subtraction whose sign (corrected for overflow) becomes bit 0
    assign slice_op = (ctrl_q[1:0] == OP_SLT) ? OP_ADD : ctrl_q[1:0];

    ALU_1bit u_slice (
        .a        (a_sh_q[0]),
        .b        (b_sh_q[0]),
        .a_invert (ctrl_q[3]),
        .b_invert (ctrl_q[2]),
        .carry_in (carry_q),
        .less     (1'b0),
        .operation(slice_op),
        .result   (slice_res),
        .carry_out(slice_co)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        r_sh_d    = r_sh_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        set_d     = set_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_out_d = ovf_out_q;
        done_d    = 1'b0;
        fin       = (ctrl_q[1:0] == OP_SLT) ? WIDTH'(set_q) : r_sh_q;
        case (state_q)
            S_IDLE: if (start_in) begin
                a_sh_d  = a_in;
                b_sh_d  = b_in;
                ctrl_d  = ctrl_in;
                carry_d = ctrl_in[2];
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                carry_d = slice_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = {slice_res, r_sh_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    ovf_d   = carry_q ^ slice_co;
                    set_d   = slice_res ^ carry_q ^ slice_co;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                result_d  = fin;
                zero_d    = (fin == '0);
                ovf_out_d = (ctrl_q[1:0] == OP_ADD) & ovf_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            r_sh_q    <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            set_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            r_sh_q    <= r_sh_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            set_q     <= set_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_out_q <= ovf_out_d;
            done_q    <= done_d;
        end
    end

    assign busy_out     = (state_q != S_IDLE);
    assign done_out     = done_q;
    assign result_out   = result_q;
    assign zero_out     = zero_q;
    assign overflow_out = ovf_out_q;
endmodule

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: scoreboard bench comparing the bit-serial ALU against an arithmetic reference.
import alu_pkg::*;

module tb_bit_serial_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [3:0]   ctrl = '0;
    logic         busy, done, zero, ovf;
    logic [W-1:0] res;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0, busy_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk_in      (clk),
        .reset_in    (rst),
        .start_in    (start),
        .a_in        (a),
        .b_in        (b),
        .ctrl_in     (ctrl),
        .busy_out    (busy),
        .done_out    (done),
        .result_out  (res),
        .zero_out    (zero),
        .overflow_out(ovf)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: operate on whole (optionally inverted) operands, overflow from exact signed sum.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] c);
        logic [W-1:0] xx, yy;
        longint       s;
        exp_t         e;
        xx = c[3] ? ~x : x;
        yy = c[2] ? ~y : y;
        s  = longint'($signed(xx)) + longint'($signed(yy)) + longint'(c[2]);
        case (c[1:0])
            2'b00:   e.r = xx & yy;
            2'b01:   e.r = xx | yy;
            2'b10:   e.r = xx + yy + W'(c[2]);
            default: e.r = W'(s < 0);
        endcase
        e.z = (e.r == '0);
        e.o = (c[1:0] == 2'b10) && (s > (longint'(1) <<< (W-1)) - 1 || s < -(longint'(1) <<< (W-1)));
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) busy_cnt = 0;
        else begin
            if (busy) busy_cnt++;
            if (done) begin
                exp_t e;
                done_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = q.pop_front();
                    check("result", res, e.r);
                    check("zero", W'(zero), W'(e.z));
                    check("overflow", W'(ovf), W'(e.o));
                    check("busy_cycles", W'(busy_cnt), W'(W + 1));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        failures++;
        $display("FAIL done_timeout actual=0 expected=1");
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] c);
        a = x;
        b = y;
        ctrl = c;
        start = 1'b1;
        q.push_back(model(x, y, c));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic poke_junk();
        a = $urandom;
        b = $urandom;
        ctrl = 4'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [W-1:0] da[15] = '{32'd7, 32'd5, 32'd5, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                             32'hFFFFFFFF, 32'h80000000, 32'd1, 32'd0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                             32'h80000000, 32'hFFFFFFFF, 32'h12345678};
    logic [W-1:0] db[15] = '{32'd5, 32'd5, 32'd7, 32'd1, 32'd1, 32'd1,
                             32'd1, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h0F0F0F0F, 32'h0F0F0F0F,
                             32'h80000000, 32'hFFFFFFFF, 32'h0F0F0F0F};
    logic [3:0]   dc[15] = '{CTRL_ADD, CTRL_SUB, CTRL_SUB, CTRL_ADD, CTRL_SUB, CTRL_AND,
                             CTRL_SLT, CTRL_SLT, CTRL_SLT, CTRL_NOR, CTRL_OR, CTRL_AND,
                             CTRL_ADD, 4'b1101, CTRL_ADD};

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        check("reset_result", res, '0);
        check("reset_flags", W'({zero, ovf, busy, done}), '0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            launch(da[i], db[i], dc[i]);
            wait_done();
        end
        // in-flight starts at cycles 5 and 20 must not disturb the operation
        launch(32'h00001234, 32'h00000FFF, CTRL_SUB);
        repeat (3) @(negedge clk);
        poke_junk();
        repeat (14) @(negedge clk);
        poke_junk();
        wait_done();
        launch(32'hF0F0F0F0, 32'h0F0F0F0F, CTRL_OR);
        wait_done();
        // asynchronous reset mid-run aborts without a done pulse
        launch(32'h7FFFFFFF, 32'd1, CTRL_ADD);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_result", res, '0);
        check("abort_flags", W'({zero, ovf, busy, done}), '0);
        q.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * W) @(negedge clk);
        check("abort_no_done", W'(done_cnt), W'(d0));
        launch(32'd100, 32'd58, CTRL_SUB);
        wait_done();
        for (int i = 0; i < 40; i++) begin
            launch($urandom, $urandom, 4'($urandom));
            wait_done();
        end
        @(negedge clk);
        check("queue_empty", W'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
